// File: rtl/npu_stream_loader.sv
// Streaming load/read sequencer for npu_simple: writes bias, weight and input rows
// from a LANES-byte stream, then sweeps the read port over every column group.
module npu_stream_loader #(
  parameter int unsigned WIDTH    = 80,
  parameter int unsigned HEIGHT   = 8,
  parameter int unsigned WIDTH_B  = 7,
  parameter int unsigned HEIGHT_B = 3,
  parameter int unsigned LANES    = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        skip_params,
  input  logic [8*LANES-1:0]          s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [WIDTH_B-1:0]          write_w,
  output logic [HEIGHT_B-1:0]         write_h,
  output logic [8*LANES-1:0]          data_in,
  output logic [LANES-1:0]            en_in,
  output logic [WIDTH_B*LANES-1:0]    readi_w,
  output logic [HEIGHT_B*LANES-1:0]   readi_h,
  output logic [LANES-1:0]            en_read,
  output logic                        en_bias,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IN_COLS = WIDTH - LANES;
  localparam int unsigned WPR     = (IN_COLS + LANES - 1) / LANES;
  localparam int unsigned REM     = IN_COLS - (WPR - 1) * LANES;
  localparam int unsigned NGRP    = (WIDTH + LANES - 1) / LANES;
  localparam int unsigned MAXC    = (WPR > NGRP) ? WPR : NGRP;
  localparam int unsigned CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [LANES-1:0]    ALL_MASK  = '1;
  // Bias is a 16-bit value carried in the two most significant lanes.
  localparam logic [LANES-1:0]    BIAS_MASK = ALL_MASK << (LANES - 2);
  localparam logic [LANES-1:0]    REM_MASK  = ALL_MASK << (LANES - REM);
  localparam logic [HEIGHT_B-1:0] ROW_LAST  = HEIGHT_B'(HEIGHT - 1);
  localparam logic [CW-1:0]       WPR_LAST  = CW'(WPR - 1);
  localparam logic [CW-1:0]       GRP_LAST  = CW'(NGRP - 1);
  localparam logic [WIDTH_B-1:0]  BIAS_COL  = WIDTH_B'(WIDTH);
  localparam logic [WIDTH_B-1:0]  WGT_COL   = WIDTH_B'(WIDTH - LANES);

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    WEIGHT,
    INPUT,
    READ,
    DONE
  } state_t;

  state_t                    state;
  logic [HEIGHT_B-1:0]       row_cnt;
  logic [CW-1:0]             col_cnt;
  logic                      hs;
  logic [WIDTH_B-1:0]        in_col;
  logic [WIDTH_B*LANES-1:0]  rd_w_nxt;
  logic [LANES-1:0]          rd_en_nxt;

  assign hs = s_valid & s_ready;

  // Per-lane read column for the current group; lanes past the last column are masked.
  always_comb begin
    int unsigned col;
    col       = 0;
    rd_w_nxt  = '0;
    rd_en_nxt = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      col = 32'(col_cnt) * LANES + j;
      rd_w_nxt[(LANES-1-j)*WIDTH_B +: WIDTH_B] = col[WIDTH_B-1:0];
      rd_en_nxt[LANES-1-j] = (col < WIDTH);
    end
    in_col = WIDTH_B'(32'(col_cnt) * LANES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      write_w <= '0;
      write_h <= '0;
      data_in <= '0;
      en_in   <= '0;
      readi_w <= '0;
      readi_h <= '0;
      en_read <= '0;
      en_bias <= 1'b0;
    end else begin
      en_in   <= '0;
      en_read <= '0;
      en_bias <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt <= '0;
            col_cnt <= '0;
            busy    <= 1'b1;
            s_ready <= 1'b1;
            state   <= skip_params ? INPUT : BIAS;
          end
        end
        BIAS: begin
          if (hs) begin
            write_w <= BIAS_COL;
            write_h <= row_cnt;
            data_in <= s_data;
            en_in   <= BIAS_MASK;
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= WEIGHT;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        WEIGHT: begin
          if (hs) begin
            write_w <= WGT_COL;
            write_h <= row_cnt;
            data_in <= s_data;
            en_in   <= ALL_MASK;
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= INPUT;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        INPUT: begin
          if (hs) begin
            write_w <= in_col;
            write_h <= row_cnt;
            data_in <= s_data;
            en_in   <= (col_cnt == WPR_LAST) ? REM_MASK : ALL_MASK;
            if (col_cnt == WPR_LAST) begin
              col_cnt <= '0;
              if (row_cnt == ROW_LAST) begin
                row_cnt <= '0;
                s_ready <= 1'b0;
                state   <= READ;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        READ: begin
          readi_w <= rd_w_nxt;
          readi_h <= {LANES{row_cnt}};
          en_read <= rd_en_nxt;
          en_bias <= 1'b1;
          if (col_cnt == GRP_LAST) begin
            col_cnt <= '0;
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          s_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
